// File: rtl/kernel_launch_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kernel_launch_ctrl_if : batch command, kernel ap_* control and result stream
// Rev 1.0
// ----------------------------------------------------------------------------
interface kernel_launch_ctrl_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [COUNT_WIDTH-1:0] cmd_count;
  logic                   ap_start;
  logic                   ap_ready;
  logic                   ap_done;
  logic [DATA_WIDTH-1:0]  kernel_out0;
  logic                   res_valid;
  logic                   res_ready;
  logic [DATA_WIDTH-1:0]  res_data;
  logic                   res_last;
  logic [COUNT_WIDTH-1:0] last_latency;
  logic                   batch_done;
  logic                   timeout_err;

  modport master (
    input  cmd_valid, cmd_count, ap_ready, ap_done, kernel_out0, res_ready,
    output cmd_ready, ap_start, res_valid, res_data, res_last, last_latency,
           batch_done, timeout_err
  );

  modport slave (
    output cmd_valid, cmd_count, ap_ready, ap_done, kernel_out0, res_ready,
    input  cmd_ready, ap_start, res_valid, res_data, res_last, last_latency,
           batch_done, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/kernel_launch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kernel_launch_ctrl : batch launcher for an ap_ctrl kernel with watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
module kernel_launch_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  kernel_launch_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [COUNT_WIDTH-1:0] ONE_C     = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C = COUNT_WIDTH'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic [COUNT_WIDTH-1:0] latency_q, latency_d;
  logic [DATA_WIDTH-1:0]  res_data_q, res_data_d;
  logic                   res_valid_q, res_valid_d;
  logic                   res_last_q, res_last_d;
  logic                   batch_done_q, batch_done_d;
  logic                   cmd_ready_c, ap_start_c, res_pop_c;
  logic [COUNT_WIDTH-1:0] run_cnt_inc_c;

  assign run_cnt_inc_c = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + ONE_C;
  assign res_pop_c     = res_valid_q && bus.res_ready;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    run_cnt_d    = run_cnt_q;
    latency_d    = latency_q;
    res_data_d   = res_data_q;
    res_valid_d  = res_valid_q;
    res_last_d   = res_last_q;
    batch_done_d = 1'b0;
    cmd_ready_c  = 1'b0;
    ap_start_c   = 1'b0;
    if (res_pop_c) res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          if (bus.cmd_count == '0) begin
            batch_done_d = 1'b1;
          end else begin
            remaining_d = bus.cmd_count;
            state_d     = S_START;
          end
        end
      end
      S_START: begin
        // Only launch into an empty slot so the ap_done capture always has room.
        ap_start_c = !res_valid_q;
        if (ap_start_c && bus.ap_ready) begin
          run_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_inc_c;
        if (bus.ap_done) begin
          res_data_d  = bus.kernel_out0;
          res_valid_d = 1'b1;
          res_last_d  = (remaining_q == ONE_C);
          latency_d   = run_cnt_inc_c;
          remaining_d = remaining_q - ONE_C;
          state_d     = (remaining_q == ONE_C) ? S_DRAIN : S_START;
        end else if ((TIMEOUT != 0) && (run_cnt_inc_c == TIMEOUT_C)) begin
          state_d = S_ERROR;
        end
      end
      S_DRAIN: begin
        if (res_pop_c) begin
          batch_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      run_cnt_q    <= '0;
      latency_q    <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      res_last_q   <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      run_cnt_q    <= run_cnt_d;
      latency_q    <= latency_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      res_last_q   <= res_last_d;
      batch_done_q <= batch_done_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_c && !rst;
  assign bus.ap_start     = ap_start_c;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_last     = res_last_q;
  assign bus.last_latency = latency_q;
  assign bus.batch_done   = batch_done_q;
  assign bus.timeout_err  = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_kernel_launch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_kernel_launch_ctrl: emulated kernel and result sink; each batch is compared
// against a transaction-level expectation (values in order, last flag, latency).
module tb_kernel_launch_ctrl;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int TO  = 16;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  kernel_launch_ctrl_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  kernel_launch_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] vals[$];
  int            dlys[$];
  logic [DW-1:0] k_val_q[$];
  int            k_dly_q[$];
  int            k_acc_q[$];
  int            k_stall = 0, k_stall_cnt = 0, k_cnt = 0, k_cur_dly = 0;
  logic [DW-1:0] k_cur_val = '0;
  bit            k_busy = 1'b0, k_spur = 1'b0, start_pend = 1'b0;
  int            sink_mode = 0, sink_hold = 0, sink_cnt = 0;
  logic [DW-1:0] got_data[$];
  bit            got_last[$];
  int            got_lat[$];
  int            last_pop_edge = 0, bd_cnt = 0, bd_edge = 0, viol_full = 0, stall_drop = 0;

  function automatic int exp_lat(input int d);
    return (d > SAT) ? SAT : d;
  endfunction

  // Kernel emulator, result sink and monitor; delay 0 means the kernel never finishes.
  initial begin
    bus.ap_ready    = 1'b1;
    bus.ap_done     = 1'b0;
    bus.kernel_out0 = '0;
    bus.res_ready   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        k_busy = 1'b0; k_stall_cnt = 0; sink_cnt = 0; start_pend = 1'b0; k_spur = 1'b0;
        k_val_q.delete(); k_dly_q.delete();
        bus.ap_done = 1'b0; bus.ap_ready = 1'b1; bus.res_ready = 1'b0;
        continue;
      end
      if (bus.batch_done) begin bd_cnt++; bd_edge = cyc; end
      if (bus.ap_start && bus.res_valid) viol_full++;
      if (start_pend && !bus.ap_start) stall_drop++;

      case (sink_mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        default: bus.res_ready = bus.res_valid && (sink_cnt >= sink_hold);
      endcase
      if (bus.res_valid) begin
        if (bus.res_ready) begin
          got_data.push_back(bus.res_data);
          got_last.push_back(bus.res_last);
          got_lat.push_back(int'(bus.last_latency));
          last_pop_edge = cyc + 1;
          sink_cnt = 0;
        end else begin
          sink_cnt++;
        end
      end

      bus.ap_done = 1'b0;
      if (k_busy) begin
        bus.ap_ready = 1'b0;
        k_cnt++;
        if (k_cur_dly != 0 && k_cnt == k_cur_dly) begin
          bus.ap_done     = 1'b1;
          bus.kernel_out0 = k_cur_val;
          k_busy          = 1'b0;
        end
      end else if (k_spur) begin
        bus.ap_done     = 1'b1;
        bus.kernel_out0 = 8'hEE;
        bus.ap_ready    = 1'b1;
        k_spur          = 1'b0;
      end else if (bus.ap_start) begin
        if (k_stall_cnt < k_stall) begin
          bus.ap_ready = 1'b0;
          k_stall_cnt++;
        end else begin
          bus.ap_ready = 1'b1;
          k_stall_cnt  = 0;
          k_busy       = 1'b1;
          k_cnt        = 0;
          k_acc_q.push_back(cyc + 1);
          k_cur_dly = (k_dly_q.size() > 0) ? k_dly_q.pop_front() : 3;
          k_cur_val = (k_val_q.size() > 0) ? k_val_q.pop_front() : 8'h00;
        end
      end else begin
        bus.ap_ready = 1'b1;
      end
      start_pend = bus.ap_start && !bus.ap_ready;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_cmd(input int n, output int acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_count = CW'(n);
    for (int i = 0; i < 200 && bus.cmd_ready !== 1'b1; i++) step();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", bus.cmd_ready);
      acc = -1;
    end else begin
      acc = cyc + 1;
    end
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_batch(output int acc, output bit fin);
    int bd0;
    got_data.delete(); got_last.delete(); got_lat.delete(); k_acc_q.delete();
    foreach (vals[i]) begin
      k_val_q.push_back(vals[i]);
      k_dly_q.push_back(dlys[i]);
    end
    bd0 = bd_cnt;
    issue_cmd(vals.size(), acc);
    fin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bd_cnt != bd0) begin fin = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({bus.cmd_ready, bus.ap_start, bus.res_valid, bus.res_data, bus.res_last,
         bus.last_latency, bus.batch_done, bus.timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b st=%b rv=%b rd=%h rl=%b lat=%0d bd=%b te=%b required all 0",
               bus.cmd_ready, bus.ap_start, bus.res_valid, bus.res_data, bus.res_last,
               bus.last_latency, bus.batch_done, bus.timeout_err);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_single();
    int acc; bit fin;
    vals = '{8'h3C}; dlys = '{5}; sink_mode = 0; k_stall = 0;
    run_batch(acc, fin);
    checks++;
    if (!fin || got_data.size() != 1) begin
      failures++;
      $display("FAIL single_count: finished=%b results=%0d required 1/1", fin, got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 8'h3C || got_last[0] !== 1'b1 || got_lat[0] != 5) begin
        failures++;
        $display("FAIL single_result: data=%h last=%b lat=%0d required 3c/1/5",
                 got_data[0], got_last[0], got_lat[0]);
      end
      checks++;
      if (k_acc_q.size() != 1 || k_acc_q[0] != acc + 1 || last_pop_edge != k_acc_q[0] + 6
          || bd_edge != last_pop_edge) begin
        failures++;
        $display("FAIL single_timing: cmd=%0d start=%0d pop=%0d bd=%0d required start=cmd+1 pop=start+6 bd=pop",
                 acc, (k_acc_q.size() > 0) ? k_acc_q[0] : -1, last_pop_edge, bd_edge);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc; bit fin; int v0;
    vals = '{8'h01, 8'h02, 8'h03};
    dlys = '{$urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12)};
    sink_mode = 2; sink_hold = 10; v0 = viol_full;
    run_batch(acc, fin);
    checks++;
    if (!fin || got_data.size() != 3) begin
      failures++;
      $display("FAIL backpressure_count: finished=%b results=%0d required 1/3", fin, got_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_data[i] !== vals[i] || got_last[i] !== (i == 2) || got_lat[i] != exp_lat(dlys[i])) begin
          failures++;
          $display("FAIL backpressure_result[%0d]: data=%h last=%b lat=%0d required %h/%b/%0d",
                   i, got_data[i], got_last[i], got_lat[i], vals[i], (i == 2), exp_lat(dlys[i]));
        end
      end
    end
    checks++;
    if (viol_full != v0) begin
      failures++;
      $display("FAIL backpressure_start_while_full: cycles=%0d required 0", viol_full - v0);
    end
    sink_mode = 0;
  endtask

  task automatic test_zero_count();
    int acc; int bd0;
    k_acc_q.delete(); bd0 = bd_cnt;
    issue_cmd(0, acc);
    checks++;
    if (bus.batch_done !== 1'b1 || bd_edge != acc || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_count_pulse: batch_done=%b at=%0d cmd_ready=%b required 1 at %0d, ready 1",
               bus.batch_done, bd_edge, bus.cmd_ready, acc);
    end
    repeat (5) step();
    checks++;
    if (k_acc_q.size() != 0 || bd_cnt != bd0 + 1 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_count_after: starts=%0d pulses=%0d ready=%b required 0/1/1",
               k_acc_q.size(), bd_cnt - bd0, bus.cmd_ready);
    end
  endtask

  task automatic test_ready_stall();
    int acc; bit fin; int s0;
    vals = '{8'($urandom), 8'($urandom)};
    dlys = '{$urandom_range(1, 15), $urandom_range(1, 15)};
    sink_mode = 0; k_stall = 7; s0 = stall_drop;
    run_batch(acc, fin);
    k_stall = 0;
    checks++;
    if (!fin || got_data.size() != 2 || k_acc_q.size() != 2) begin
      failures++;
      $display("FAIL stall_count: finished=%b results=%0d starts=%0d required 1/2/2",
               fin, got_data.size(), k_acc_q.size());
    end else begin
      checks++;
      if (k_acc_q[0] != acc + 8 || stall_drop != s0) begin
        failures++;
        $display("FAIL stall_hold: start_edge=%0d drops=%0d required %0d/0", k_acc_q[0], stall_drop - s0, acc + 8);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_data[i] !== vals[i] || got_last[i] !== (i == 1) || got_lat[i] != exp_lat(dlys[i])) begin
          failures++;
          $display("FAIL stall_result[%0d]: data=%h last=%b lat=%0d required %h/%b/%0d",
                   i, got_data[i], got_last[i], got_lat[i], vals[i], (i == 1), exp_lat(dlys[i]));
        end
      end
    end
  endtask

  task automatic test_spurious_done();
    logic [CW-1:0] lat0;
    lat0 = bus.last_latency;
    got_data.delete();
    k_spur = 1'b1;
    repeat (4) step();
    checks++;
    if (got_data.size() != 0 || bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.last_latency !== lat0) begin
      failures++;
      $display("FAIL spurious_done: results=%0d res_valid=%b ready=%b lat=%0d required 0/0/1/%0d",
               got_data.size(), bus.res_valid, bus.cmd_ready, bus.last_latency, lat0);
    end
  endtask

  task automatic test_random_batches();
    int acc; bit fin; int n; int v0;
    for (int b = 0; b < 4; b++) begin
      n = $urandom_range(1, 5);
      vals.delete(); dlys.delete();
      for (int i = 0; i < n; i++) begin
        vals.push_back(8'($urandom));
        dlys.push_back($urandom_range(1, TO - 1));
      end
      sink_mode = 1; k_stall = $urandom_range(0, 3); v0 = viol_full;
      run_batch(acc, fin);
      checks++;
      if (!fin || got_data.size() != n || viol_full != v0) begin
        failures++;
        $display("FAIL random_batch%0d_count: finished=%b results=%0d full_starts=%0d required 1/%0d/0",
                 b, fin, got_data.size(), viol_full - v0, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (got_data[i] !== vals[i] || got_last[i] !== (i == n - 1) || got_lat[i] != exp_lat(dlys[i])) begin
            failures++;
            $display("FAIL random_batch%0d_result[%0d]: data=%h last=%b lat=%0d required %h/%b/%0d",
                     b, i, got_data[i], got_last[i], got_lat[i], vals[i], (i == n - 1), exp_lat(dlys[i]));
          end
        end
      end
    end
    sink_mode = 0; k_stall = 0;
  endtask

  task automatic test_reset_mid_run();
    int acc; bit fin;
    got_data.delete(); k_acc_q.delete();
    vals = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    dlys = '{3, 12, 12, 12};
    foreach (vals[i]) begin k_val_q.push_back(vals[i]); k_dly_q.push_back(dlys[i]); end
    sink_mode = 0;
    issue_cmd(4, acc);
    for (int i = 0; i < 200 && k_acc_q.size() < 2; i++) step();
    repeat (3) step();
    checks++;
    if (k_acc_q.size() != 2 || bus.last_latency !== CW'(3)) begin
      failures++;
      $display("FAIL midrun_before_reset: starts=%0d lat=%0d required 2/3", k_acc_q.size(), bus.last_latency);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({bus.cmd_ready, bus.ap_start, bus.res_valid, bus.res_last, bus.last_latency,
         bus.batch_done, bus.timeout_err} !== '0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: rdy=%b st=%b rv=%b rl=%b lat=%0d bd=%b te=%b required all 0",
               bus.cmd_ready, bus.ap_start, bus.res_valid, bus.res_last, bus.last_latency,
               bus.batch_done, bus.timeout_err);
    end
    rst = 1'b0;
    step(); step();
    vals = '{8'($urandom)}; dlys = '{$urandom_range(1, 15)};
    run_batch(acc, fin);
    checks++;
    if (!fin || got_data.size() != 1 || got_data[0] !== vals[0] || got_last[0] !== 1'b1
        || got_lat[0] != exp_lat(dlys[0])) begin
      failures++;
      $display("FAIL midrun_new_batch: finished=%b results=%0d data=%h lat=%0d required 1/1/%h/%0d",
               fin, got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'h00,
               (got_lat.size() > 0) ? got_lat[0] : -1, vals[0], exp_lat(dlys[0]));
    end
  endtask

  task automatic test_watchdog();
    int acc; bit fin; int a; int bd0;
    vals = '{8'h5A}; dlys = '{TO}; sink_mode = 0;
    run_batch(acc, fin);
    checks++;
    if (!fin || got_data.size() != 1 || got_data[0] !== 8'h5A || got_lat[0] != TO || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_done_on_limit: finished=%b results=%0d lat=%0d err=%b required 1/1/%0d/0",
               fin, got_data.size(), (got_lat.size() > 0) ? got_lat[0] : -1, bus.timeout_err, TO);
    end
    k_acc_q.delete();
    k_val_q.push_back(8'hA5); k_dly_q.push_back(0);
    issue_cmd(1, acc);
    for (int i = 0; i < 200 && k_acc_q.size() == 0; i++) step();
    a = (k_acc_q.size() > 0) ? k_acc_q[0] : cyc;
    for (int i = 0; i < 200 && cyc < a + TO - 1; i++) step();
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_early: timeout_err=%b one cycle before limit, required 0", bus.timeout_err);
    end
    step();
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.ap_start !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_trip: err=%b ready=%b start=%b required 1/0/0",
               bus.timeout_err, bus.cmd_ready, bus.ap_start);
    end
    bd0 = bd_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_count = CW'(1);
    repeat (4) step();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.cmd_ready !== 1'b0 || bd_cnt != bd0 || k_acc_q.size() != 1) begin
      failures++;
      $display("FAIL watchdog_sticky: err=%b ready=%b pulses=%0d starts=%0d required 1/0/0/1",
               bus.timeout_err, bus.cmd_ready, bd_cnt - bd0, k_acc_q.size());
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL watchdog_reset_clear: err=%b ready=%b required 0/1", bus.timeout_err, bus.cmd_ready);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_count = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_zero_count();
    test_ready_stall();
    test_spurious_done();
    test_random_batches();
    test_reset_mid_run();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation reached %0t without finishing", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule
`default_nettype wire
